// File: rtl/data_hs_rx_if.sv
// Signal bundle between the HS lane front end and the byte aligner.
// The master drives raw words and the HS enable; the slave returns aligned bytes and status.
interface data_hs_rx_if;
    logic        hs_en;
    logic [7:0]  rx_word;
    logic [7:0]  data;
    logic        data_valid;
    logic        active;
    logic [2:0]  offset;
    logic        sync_ok;
    logic        sync_err;
    logic [15:0] byte_cnt;

    modport master (
        output hs_en,
        output rx_word,
        input  data,
        input  data_valid,
        input  active,
        input  offset,
        input  sync_ok,
        input  sync_err,
        input  byte_cnt
    );

    modport slave (
        input  hs_en,
        input  rx_word,
        output data,
        output data_valid,
        output active,
        output offset,
        output sync_ok,
        output sync_err,
        output byte_cnt
    );
endinterface

// File: rtl/data_hs_rx.sv
// HS burst receiver: hunts for the leader sync byte at any bit offset in the raw word stream,
// then delivers byte-aligned payload until the lane leaves HS mode.
module data_hs_rx #(
    parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
    parameter int unsigned HUNT_MAX     = 16
) (
    input  logic         byte_clk,
    input  logic         byte_rst_n,
    data_hs_rx_if.slave  rx
);

    localparam int unsigned HCW = (HUNT_MAX < 2) ? 1 : $clog2(HUNT_MAX + 1);
    localparam logic [HCW-1:0] HUNT_LAST = HCW'(HUNT_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StLock,
        StErr
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     prev_q;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic [2:0]     offset_q, offset_d;
    logic           sync_ok_q, sync_ok_d;
    logic           sync_err_q, sync_err_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [HCW-1:0] hunt_q, hunt_d;

    logic [15:0]    win;
    logic           match_any;
    logic [2:0]     match_off;
    logic [7:0]     lock_byte;

    // Bit 0 of the window is the earliest received bit.
    assign win       = {rx.rx_word, prev_q};
    assign lock_byte = 8'(win >> offset_q);

    // Scan from the top so the lowest matching offset wins.
    always_comb begin
        match_any = 1'b0;
        match_off = 3'd0;
        for (int o = 7; o >= 0; o--) begin
            if (8'(win >> o) == SYNC_PATTERN) begin
                match_any = 1'b1;
                match_off = 3'(o);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        offset_d   = offset_q;
        sync_ok_d  = 1'b0;
        sync_err_d = 1'b0;
        cnt_d      = cnt_q;
        hunt_d     = hunt_q;

        // Leaving HS mode overrides any match or timeout seen in the same cycle.
        if (!rx.hs_en) begin
            state_d = StIdle;
            hunt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHunt;
                    hunt_d  = '0;
                end
                StHunt: begin
                    if (match_any) begin
                        state_d   = StLock;
                        offset_d  = match_off;
                        sync_ok_d = 1'b1;
                        cnt_d     = '0;
                    end else if (hunt_q == HUNT_LAST) begin
                        state_d    = StErr;
                        sync_err_d = 1'b1;
                    end else begin
                        hunt_d = hunt_q + 1'b1;
                    end
                end
                StLock: begin
                    data_d  = lock_byte;
                    valid_d = 1'b1;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge byte_clk) begin
        if (!byte_rst_n) begin
            state_q    <= StIdle;
            prev_q     <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            offset_q   <= 3'd0;
            sync_ok_q  <= 1'b0;
            sync_err_q <= 1'b0;
            cnt_q      <= 16'h0000;
            hunt_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= rx.hs_en ? rx.rx_word : 8'h00;
            data_q     <= data_d;
            valid_q    <= valid_d;
            offset_q   <= offset_d;
            sync_ok_q  <= sync_ok_d;
            sync_err_q <= sync_err_d;
            cnt_q      <= cnt_d;
            hunt_q     <= hunt_d;
        end
    end

    assign rx.data       = data_q;
    assign rx.data_valid = valid_q;
    assign rx.active     = (state_q == StLock);
    assign rx.offset     = offset_q;
    assign rx.sync_ok    = sync_ok_q;
    assign rx.sync_err   = sync_err_q;
    assign rx.byte_cnt   = cnt_q;

endmodule

// File: tb/tb_data_hs_rx.sv
// Bench for data_hs_rx: directed bursts with literal expectations plus a per-cycle
// behavioural model of burst framing compared against every output.
module tb_data_hs_rx;
    localparam logic [7:0] SYNC = 8'hB8;
    localparam int         HMAX = 16;

    logic byte_clk   = 1'b0;
    logic byte_rst_n = 1'b0;

    data_hs_rx_if bus ();

    data_hs_rx #(
        .SYNC_PATTERN (SYNC),
        .HUNT_MAX     (HMAX)
    ) dut (
        .byte_clk   (byte_clk),
        .byte_rst_n (byte_rst_n),
        .rx         (bus.slave)
    );

    always #5 byte_clk = ~byte_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: phase 0 waiting, 1 searching, 2 streaming, 3 gave up.
    int         ph     = 0;
    int         hunt_n = 0;
    int         m_cnt  = 0;
    int         m_off  = 0;
    logic [7:0] m_prev = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_dv   = 1'b0;
    logic       m_sok  = 1'b0;
    logic       m_serr = 1'b0;
    bit         live   = 1'b0;

    always @(posedge byte_clk) begin
        logic        en;
        logic [7:0]  w;
        logic [15:0] win;
        int          hit;
        en = bus.hs_en;
        w  = bus.rx_word;
        if (!byte_rst_n) begin
            ph = 0; hunt_n = 0; m_cnt = 0; m_off = 0;
            m_prev = 8'h00; m_data = 8'h00; m_dv = 1'b0; m_sok = 1'b0; m_serr = 1'b0;
            live = 1'b1;
        end else begin
            win    = {w, m_prev};
            m_dv   = 1'b0;
            m_sok  = 1'b0;
            m_serr = 1'b0;
            if (!en) begin
                ph = 0;
            end else if (ph == 0) begin
                ph = 1;
                hunt_n = 0;
            end else if (ph == 1) begin
                hit = -1;
                for (int o = 7; o >= 0; o--) if (((win >> o) & 16'h00FF) == 16'(SYNC)) hit = o;
                if (hit >= 0) begin
                    m_off = hit; m_sok = 1'b1; m_cnt = 0; ph = 2;
                end else begin
                    hunt_n++;
                    if (hunt_n == HMAX) begin
                        m_serr = 1'b1;
                        ph = 3;
                    end
                end
            end else if (ph == 2) begin
                m_data = 8'(win >> m_off);
                m_dv   = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            m_prev = en ? w : 8'h00;
        end
        #1;
        if (live) begin
            check("model_ctrl",
                  {bus.data_valid, bus.active, bus.offset, bus.sync_ok, bus.sync_err, bus.byte_cnt},
                  {m_dv, (ph == 2), 3'(m_off), m_sok, m_serr, 16'(m_cnt)});
            if (m_dv) check("model_data", 32'(bus.data), 32'(m_data));
        end
    end

    task automatic step(input logic en, input logic [7:0] w);
        bus.hs_en   = en;
        bus.rx_word = w;
        @(posedge byte_clk);
        #2;
    endtask

    initial begin
        bus.hs_en   = 1'b0;
        bus.rx_word = 8'h00;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check("rst_valid", 32'(bus.data_valid), 0);
        check("rst_active", 32'(bus.active), 0);
        check("rst_offset", 32'(bus.offset), 0);
        check("rst_cnt", 32'(bus.byte_cnt), 0);
        check("rst_data", 32'(bus.data), 0);
        byte_rst_n = 1'b1;

        // Sync at bit offset 3.
        step(1'b1, 8'h00);
        step(1'b1, 8'hC0);
        check("o3_nosync_yet", 32'(bus.sync_ok), 0);
        step(1'b1, 8'hD5);
        check("o3_sync_ok", 32'(bus.sync_ok), 1);
        check("o3_offset", 32'(bus.offset), 3);
        check("o3_active", 32'(bus.active), 1);
        step(1'b1, 8'h2A);
        check("o3_data0", {bus.data_valid, bus.data}, 9'h15A);
        check("o3_sync_pulse", 32'(bus.sync_ok), 0);
        step(1'b1, 8'h05);
        check("o3_data1", {bus.data_valid, bus.data}, 9'h1A5);
        check("o3_cnt", 32'(bus.byte_cnt), 2);
        step(1'b0, 8'h00);
        check("o3_end_valid", 32'(bus.data_valid), 0);

        // Sync at offset 0; offset holds through IDLE until the new sync.
        step(1'b1, 8'h00);
        check("o0_offset_hold", 32'(bus.offset), 3);
        step(1'b1, 8'hB8);
        step(1'b1, 8'h11);
        check("o0_offset", {bus.sync_ok, bus.offset}, 4'h8);
        step(1'b1, 8'h22);
        check("o0_data0", {bus.data_valid, bus.data}, 9'h111);
        step(1'b1, 8'h44);
        check("o0_data1", {bus.data_valid, bus.data}, 9'h122);
        step(1'b0, 8'h00);

        // No sync: timeout after HMAX hunt cycles, then park until hs_en falls.
        step(1'b1, 8'h00);
        for (int i = 0; i < HMAX; i++) step(1'b1, 8'h00);
        check("nosync_err", {bus.sync_err, bus.active}, 2'b10);
        step(1'b1, 8'h00);
        check("nosync_err_pulse", 32'(bus.sync_err), 0);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        check("nosync_no_valid", 32'(bus.data_valid), 0);
        step(1'b0, 8'h00);

        // Burst of five, then a fresh burst resets the count at sync.
        step(1'b1, 8'h00);
        step(1'b1, 8'hB8);
        step(1'b1, 8'h11);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i));
        check("burst_cnt5", 32'(bus.byte_cnt), 5);
        step(1'b0, 8'h00);
        check("burst_end", {bus.data_valid, bus.active, bus.byte_cnt}, 18'h00005);
        step(1'b1, 8'hB8);
        check("burst_cnt_hold", 32'(bus.byte_cnt), 5);
        step(1'b1, 8'h11);
        check("burst_cnt_clear", {bus.sync_ok, bus.byte_cnt}, 17'h10000);
        step(1'b0, 8'h00);

        // Match in the same cycle hs_en falls: no pulse.
        step(1'b1, 8'h00);
        step(1'b1, 8'hB8);
        step(1'b0, 8'h11);
        check("simul_sync", {bus.sync_ok, bus.active}, 2'b00);

        // Timeout in the same cycle hs_en falls: no pulse.
        step(1'b1, 8'h00);
        for (int i = 0; i < HMAX - 1; i++) step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        check("simul_timeout", 32'(bus.sync_err), 0);

        // Reset while locked.
        step(1'b1, 8'h00);
        step(1'b1, 8'hC0);
        step(1'b1, 8'hD5);
        step(1'b1, 8'h2A);
        byte_rst_n = 1'b0;
        step(1'b1, 8'h33);
        check("midrst_all",
              {bus.data, bus.data_valid, bus.active, bus.offset, bus.sync_ok, bus.sync_err},
              15'h0000);
        check("midrst_cnt", 32'(bus.byte_cnt), 0);
        byte_rst_n = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Saturation.
        step(1'b1, 8'h00);
        step(1'b1, 8'hB8);
        step(1'b1, 8'h11);
        for (int i = 0; i < 70000; i++) step(1'b1, 8'(i * 7));
        check("sat_cnt", 32'(bus.byte_cnt), 32'h0000FFFF);
        check("sat_valid", 32'(bus.data_valid), 1);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_hs_rx.md
DATA_HS_RX -- requirements
Module: data_hs_rx

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 8'hB8; HS leader sync byte value, bit 0 transmitted first.
REQ-002 SHALL have parameter HUNT_MAX, default 16; maximum HUNT-state cycles before a sync error.
REQ-003 SHALL have port byte_clk  input  1  byte clock; the only clock.
REQ-004 SHALL have port byte_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port hs_en  input  1  lane is in HS receive mode (from LP state detector); low ends the burst.
REQ-006 SHALL have port rx_word  input  8  raw deserialized word, arbitrary bit alignment; bit 0 is earliest received.
REQ-007 SHALL have port data  output  8  aligned payload byte, bit 0 earliest.
REQ-008 SHALL have port data_valid  output  1  data holds a payload byte this cycle.
REQ-009 SHALL have port active  output  1  high while in LOCK.
REQ-010 SHALL have port offset  output  3  bit offset latched at sync detection.
REQ-011 SHALL have port sync_ok  output  1  one-cycle pulse on sync detection.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on hunt timeout.
REQ-013 SHALL have port byte_cnt  output  16  payload bytes delivered in the current burst, saturating at 16'hFFFF.

Function
REQ-014 SHALL register prev_word <= rx_word when hs_en=1, else prev_word <= 8'h00.
REQ-015 SHALL form a 16-bit window win = {rx_word, prev_word}; candidate byte at offset o is win[o+7:o], o = 0..7.
REQ-016 SHALL implement states IDLE, HUNT, LOCK, ERR.
REQ-017 IDLE: go to HUNT on the edge where hs_en=1; perform no matching in IDLE.
REQ-018 HUNT: each cycle compare all 8 candidates against SYNC_PATTERN; on any match latch the lowest matching o into offset, pulse sync_ok, clear byte_cnt, go to LOCK.
REQ-019 HUNT: count cycles spent in HUNT; if the count reaches HUNT_MAX without a match, pulse sync_err and go to ERR.
REQ-020 ERR: hold until hs_en=0, then go to IDLE; data_valid stays 0 in ERR.
REQ-021 LOCK: each cycle with hs_en=1, register data <= win[offset+7:offset], set data_valid=1, and increment byte_cnt (saturating).
REQ-022 Latency: if sync matches in the window sampled at cycle N, the first payload byte is the window at N+1, and it appears on data with data_valid=1 after the edge ending N+1.
REQ-023 hs_en=0 in any state SHALL move the FSM to IDLE at the next edge, with data_valid=0 from that edge.
REQ-024 hs_en=0 takes priority over a simultaneous sync match or HUNT timeout; in that case no sync_ok or sync_err pulse is issued.
REQ-025 Trailer bytes SHALL be passed through unmodified; stripping them is the upper layer's job.
REQ-026 offset and byte_cnt SHALL hold their values in IDLE until the next sync detection.
REQ-027 active SHALL be 1 exactly while the state is LOCK.

Reset
REQ-028 On a byte_clk edge with byte_rst_n=0, SHALL set state=IDLE, prev_word=0, data=0, data_valid=0, active=0, offset=0, sync_ok=0, sync_err=0, byte_cnt=0, hunt counter=0.
REQ-029 Reset asserted mid-burst SHALL abort it; no data_valid is issued until a new sync is found after hs_en rises again.

Verification
REQ-030 Offset-3 sync: hs_en=1; words 0x00, 0xC0, 0xD5, 0x2A, ... -> sync_ok once, offset=3, first data=0x5A, second data=0xA5 (upper bits from the next word), byte_cnt=2.
REQ-031 Offset-0 sync: words 0x00, 0xB8, 0x11, 0x22 -> offset=0; data 0x11 then 0x22, each one cycle after its word plus one register stage.
REQ-032 No sync: hs_en=1 with constant 0x00 for 20 cycles -> sync_err pulse after 16 HUNT cycles; no data_valid; FSM returns to IDLE only after hs_en falls.
REQ-033 Burst end: hs_en drops after 5 payload bytes -> data_valid=0 next edge, active=0, byte_cnt holds 5; next burst restarts byte_cnt at 0.
REQ-034 Simultaneous events: sync match in the same cycle hs_en falls -> no sync_ok, FSM goes to IDLE; byte_rst_n=0 during LOCK -> all outputs at reset values next edge.
REQ-035 Saturation: force a 70000-byte burst -> byte_cnt stops at 16'hFFFF while data_valid continues.
